// File: rtl/mmm_from_mont.sv
// Montgomery-domain exit converter: r = a * 2^-K mod m using K serial radix-2
// reduction steps followed by one conditional subtract.
module mmm_from_mont #(
    parameter int unsigned K = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K:0]   a_i,
    input  logic [K-1:0] m_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] r_o,
    output logic         err_o
);

    localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [K:0]      s_q, s_d;
    logic [K-1:0]    m_q, m_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [K-1:0]    r_q, r_d;
    logic            err_q, err_d;

    logic [K:0]      s_step;
    logic [K-1:0]    s_minus_m;
    logic            s_ge_m;

    // (s + s[0]*m) >> 1 evaluated as halves: for odd s and odd m the two
    // dropped LSBs sum to exactly 2, contributing +1. Needs no carry-out bit.
    always_comb begin
        s_step = {1'b0, s_q[K:1]};
        if (s_q[0]) begin
            s_step = {1'b0, s_q[K:1]} + {2'b00, m_q[K-1:1]} + {{K{1'b0}}, 1'b1};
        end
    end

    // Result is < m < 2^K whenever the subtract is taken, so K bits suffice.
    assign s_minus_m = s_q[K-1:0] - m_q;
    assign s_ge_m    = (s_q >= {1'b0, m_q});

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d   = a_i;
                    m_d   = m_i;
                    cnt_d = '0;
                    // An even modulus skips reduction; FIX reports the error one
                    // edge after accept.
                    state_d = m_i[0] ? StRun : StFix;
                end
            end
            StRun: begin
                s_d   = s_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!m_q[0]) begin
                    r_d   = '0;
                    err_d = 1'b1;
                end else begin
                    r_d   = s_ge_m ? s_minus_m : s_q[K-1:0];
                    err_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign r_o       = r_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mmm_from_mont.sv
// Self-checking bench for mmm_from_mont at K=8 and K=64 against a modular-inverse
// reference model.
module tb_mmm_from_mont;

    localparam int unsigned K8  = 8;
    localparam int unsigned K64 = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          iv8, ir8, ov8, or8, e8;
    logic [K8:0]   a8;
    logic [K8-1:0] m8, r8;

    logic           iv64, ir64, ov64, or64, e64;
    logic [K64:0]   a64;
    logic [K64-1:0] m64, r64;

    int checks = 0;
    int errors = 0;

    mmm_from_mont #(.K(K8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a_i(a8), .m_i(m8),
        .out_valid(ov8), .out_ready(or8), .r_o(r8), .err_o(e8)
    );

    mmm_from_mont #(.K(K64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a_i(a64), .m_i(m64),
        .out_valid(ov64), .out_ready(or64), .r_o(r64), .err_o(e64)
    );

    // Golden: (a mod m) * (2^-1)^k mod m, with 2^-1 = (m+1)/2 for odd m.
    function automatic logic [129:0] ref_mont(input logic [129:0] a, input logic [129:0] m,
                                              input int k);
        logic [129:0] inv2, rinv;
        inv2 = (m + 130'd1) >> 1;
        rinv = 130'd1 % m;
        for (int i = 0; i < k; i++) rinv = (rinv * inv2) % m;
        return ((a % m) * rinv) % m;
    endfunction

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic job8(input logic [8:0] a, input logic [7:0] m, output logic [7:0] r,
                        output logic e, output int lat);
        int n;
        iv8 = 1'b1; a8 = a; m8 = m;
        n = 0;
        while (!ir8 && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 200) begin @(posedge clk); #1; lat++; end
        r = r8; e = e8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic job64(input logic [64:0] a, input logic [63:0] m, output logic [63:0] r,
                         output logic e, output int lat);
        int n;
        iv64 = 1'b1; a64 = a; m64 = m;
        n = 0;
        while (!ir64 && n < 300) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv64 = 1'b0;
        lat = 0;
        while (!ov64 && lat < 200) begin @(posedge clk); #1; lat++; end
        r = r64; e = e64;
        or64 = 1'b1;
        @(posedge clk); #1;
        or64 = 1'b0;
    endtask

    initial begin
        logic [7:0]   r;
        logic [63:0]  rw;
        logic         e;
        int           lat, n, hi;
        logic [7:0]   rr;
        logic         bad;
        logic [129:0] m, a, exp;

        iv8 = 0; or8 = 0; a8 = '0; m8 = '0;
        iv64 = 0; or64 = 0; a64 = '0; m64 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_r", r8, 0);
        chk("rst_err", e8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", ir8, 1);

        job8(9'd77, 8'd179, r, e, lat);
        chk("t1_r", r, 1); chk("t1_err", e, 0); chk("t1_latency", lat, 9);
        job8(9'd27, 8'd179, r, e, lat);  chk("t2_a27", r, 5);
        job8(9'd0, 8'd179, r, e, lat);   chk("t2_a0", r, 0);
        job8(9'd179, 8'd179, r, e, lat); chk("t2_a_eq_m", r, 0);
        job8(9'd256, 8'd179, r, e, lat); chk("t3_a256", r, 1);
        job8(9'd5, 8'd1, r, e, lat);     chk("m_one", r, 0);

        job8(9'd5, 8'hB2, r, e, lat);
        chk("t4_err", e, 1); chk("t4_r", r, 0); chk("t4_latency", lat, 1);

        // Hold the result with out_ready low while a new operand is offered.
        a8 = 9'd77; m8 = 8'd179; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 200) begin @(posedge clk); #1; n++; end
        chk("t5_valid", ov8, 1);
        chk("t5_r", r8, 1);
        iv8 = 1'b1; a8 = 9'd27;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (r8 !== 8'd1 || ir8 !== 1'b0 || ov8 !== 1'b1) bad = 1'b1;
        end
        chk("t5_held_stable", bad, 0);
        iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("t5_idle_ready", ir8, 1);
        chk("t5_idle_valid", ov8, 0);
        job8(9'd27, 8'd179, r, e, lat); chk("t5_next_job", r, 5);

        // out_ready already high when FIX completes.
        or8 = 1'b1; a8 = 9'd256; m8 = 8'd179; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        hi = 0; rr = '0;
        for (int i = 0; i < 30; i++) begin
            if (ov8) begin hi++; rr = r8; end
            @(posedge clk); #1;
        end
        or8 = 1'b0;
        chk("early_ready_valid_cycles", hi, 1);
        chk("early_ready_r", rr, 1);

        // Reset in the middle of a job.
        a8 = 9'd77; m8 = 8'd179; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_valid", ov8, 0);
        rst_n = 1'b1;
        #1;
        chk("t6_rst_ready", ir8, 1);
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (ov8 !== 1'b0) bad = 1'b1;
        end
        chk("t6_no_stale_valid", bad, 0);
        job8(9'd77, 8'd179, r, e, lat);
        chk("t6_r", r, 1); chk("t6_latency", lat, 9);

        for (int i = 0; i < 2000; i++) begin
            m = 130'(2 * $urandom_range(0, 127) + 1);
            a = 130'($urandom) % (2 * m);
            exp = ref_mont(a, m, K8);
            job8(a[8:0], m[7:0], r, e, lat);
            chk("rand8_r", r, exp);
            chk("rand8_err", e, 0);
        end

        for (int i = 0; i < 300; i++) begin
            if (i == 0) m = {66'd0, 64'hFFFF_FFFF_FFFF_FFFF};
            else        m = {66'd0, $urandom, $urandom} | 130'd1;
            if (i == 0) a = 2 * m - 1;
            else        a = {34'd0, $urandom, $urandom, $urandom} % (2 * m);
            exp = ref_mont(a, m, K64);
            job64(a[64:0], m[63:0], rw, e, lat);
            chk("rand64_r", rw, exp);
            if (i == 0) chk("k64_latency", lat, 65);
        end
        job64(65'd5, 64'd10, rw, e, lat);
        chk("k64_even_err", e, 1); chk("k64_even_r", rw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
